// File: rtl/slt_iter_unit.sv
// Iterative set-less-than unit: compares a and b CHUNK bits per cycle from the MSB
// end and returns an rd-ready SLT/SLTU/SGE/SGEU result with valid/ready and flush.
// Ports:
//   clk, rst_n                  clock and async active-low reset
//   flush                       drops any in-flight or held operation
//   in_valid, in_ready          request handshake
//   a, b, op                    operands and op (op[0] unsigned, op[1] invert)
//   out_valid, out_ready        result handshake
//   result, lt, eq              zero-extended result, raw less-than, equality
module slt_iter_unit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             lt,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             inv_q, inv_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             res_q, res_d;
  logic [CHUNK-1:0] a_c, b_c;
  logic             c_lt;

  assign a_c  = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign b_c  = b_q[int'(idx_q) * CHUNK +: CHUNK];
  assign c_lt = (a_c < b_c);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    inv_d   = inv_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          // Flipping the sign bit maps signed order onto unsigned order.
          a_d     = op[0] ? a : (a ^ MSB);
          b_d     = op[0] ? b : (b ^ MSB);
          inv_d   = op[1];
          idx_d   = TOP;
          state_d = CMP;
        end
      end
      CMP: begin
        if (flush) begin
          state_d = IDLE;
        end else if (a_c != b_c) begin
          lt_d    = c_lt;
          eq_d    = 1'b0;
          res_d   = inv_q ^ c_lt;
          state_d = DONE;
        end else if (idx_q == '0) begin
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          res_d   = inv_q;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (flush) begin
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          res_d   = 1'b0;
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      inv_q   <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      inv_q   <= inv_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = WIDTH'(res_q);
  assign lt        = lt_q;
  assign eq        = eq_q;

endmodule
